// File: rtl/axis256_pack512.sv
// Packs pairs of 256-bit AXI-Stream beats into 512-bit beats, framing every
// PACKET_BEATS output beats with TLAST; FLUSH drains a held half as a padded last beat.
module axis256_pack512 #(
  parameter int unsigned PACKET_BEATS = 16,
  parameter int unsigned CW           = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         FLUSH,
  input  logic [255:0] AXIS_RX_TDATA,
  input  logic         AXIS_RX_TVALID,
  output logic         AXIS_RX_TREADY,
  output logic [511:0] AXIS_TX_TDATA,
  output logic         AXIS_TX_TVALID,
  output logic         AXIS_TX_TLAST,
  input  logic         AXIS_TX_TREADY,
  output logic         FLUSH_BUSY
);

  localparam logic [CW-1:0] LAST_COUNT = CW'(PACKET_BEATS - 1);

  logic [255:0]  lo_data;
  logic          lo_valid;
  logic [511:0]  tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          flush_pending;
  logic [CW-1:0] out_count;

  logic slot_free;
  logic rx_ready;
  logic rx_hs;
  logic tx_hs;
  logic pair_load;
  logic flush_service;
  logic flush_load;

  assign slot_free     = !tx_valid || AXIS_TX_TREADY;
  assign rx_ready      = !flush_pending && (!lo_valid || slot_free);
  assign rx_hs         = AXIS_RX_TVALID && rx_ready;
  assign tx_hs         = tx_valid && AXIS_TX_TREADY;
  assign pair_load     = rx_hs && lo_valid;
  // rx_ready is low while a flush is pending, so servicing never races a pair load
  assign flush_service = flush_pending && slot_free;
  assign flush_load    = flush_service && lo_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lo_data  <= '0;
      lo_valid <= 1'b0;
    end else if (rx_hs && !lo_valid) begin
      lo_data  <= AXIS_RX_TDATA;
      lo_valid <= 1'b1;
    end else if (pair_load || flush_load) begin
      lo_valid <= 1'b0;
    end
  end

  // A fresh load wins over retiring the current beat in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
    end else if (pair_load) begin
      tx_data  <= {AXIS_RX_TDATA, lo_data};
      tx_valid <= 1'b1;
      tx_last  <= (out_count == LAST_COUNT);
    end else if (flush_load) begin
      tx_data  <= {256'b0, lo_data};
      tx_valid <= 1'b1;
      tx_last  <= 1'b1;
    end else if (tx_hs) begin
      tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_count <= '0;
    end else if (pair_load) begin
      out_count <= (out_count == LAST_COUNT) ? '0 : out_count + CW'(1);
    end else if (flush_load) begin
      out_count <= '0;
    end
  end

  // A FLUSH arriving while one is already pending is absorbed, not queued
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_pending <= 1'b0;
    end else if (flush_service) begin
      flush_pending <= 1'b0;
    end else if (FLUSH) begin
      flush_pending <= 1'b1;
    end
  end

  assign AXIS_RX_TREADY = rx_ready;
  assign AXIS_TX_TDATA  = tx_data;
  assign AXIS_TX_TVALID = tx_valid;
  assign AXIS_TX_TLAST  = tx_last;
  assign FLUSH_BUSY     = flush_pending;

endmodule

// File: doc/axis256_pack512.md
Name: axis256_pack512

Overview:
- Sits directly in front of the 256-to-512 width stage and replaces zero-padding with real packing.
- Gathers pairs of 256-bit AXI-Stream beats into full 512-bit beats.
- Generates TLAST every PACKET_BEATS output beats, so downstream DMA/packet logic gets dense, framed data.
- A FLUSH request drains a residual half-beat as a zero-padded final beat.

Parameters:
PACKET_BEATS  16  number of 512-bit output beats per packet; TLAST on the last one; legal range 1..65535
CW  16  width of the internal output-beat counter; must hold PACKET_BEATS-1

Ports:
clk  input  1  sole clock; all logic is rising-edge
resetn  input  1  asynchronous active-low reset
FLUSH  input  1  single-cycle pulse; requests a drain of the held half-beat
AXIS_RX_TDATA  input  256  input stream data
AXIS_RX_TVALID  input  1  input valid
AXIS_RX_TREADY  output  1  input ready
AXIS_TX_TDATA  output  512  packed output data
AXIS_TX_TVALID  output  1  output valid
AXIS_TX_TLAST  output  1  end of packet
AXIS_TX_TREADY  input  1  output ready
FLUSH_BUSY  output  1  high while a flush request is pending

Behaviour:
- Reset (resetn low, asynchronous):
  - lo_valid, tx_valid, tx_last, flush_pending and out_count all clear to 0.
  - AXIS_TX_TDATA resets to 0.
  - Outputs are valid in the first cycle after reset deasserts.
- State:
  - lo_data/lo_valid: the held first half.
  - tx_data/tx_valid/tx_last: the registered output.
  - out_count: 0..PACKET_BEATS-1.
  - flush_pending: the latched flush request.
- Definitions:
  - slot_free = !tx_valid || AXIS_TX_TREADY.
  - rx_hs = RX_TVALID && RX_TREADY.
  - tx_hs = TX_TVALID && TX_TREADY.
- AXIS_RX_TREADY = !flush_pending && (!lo_valid || slot_free).
  - It is derived only from registered state and TX_TREADY.
  - It never depends on RX_TVALID.
- First beat (rx_hs with lo_valid=0): lo_data <= RX_TDATA, lo_valid <= 1. No output.
- Second beat (rx_hs with lo_valid=1):
  - tx_data <= {RX_TDATA, lo_data}, so the first beat lands in [255:0] and the second in [511:256].
  - tx_valid <= 1 and lo_valid <= 0.
  - tx_last <= (out_count == PACKET_BEATS-1).
  - out_count wraps to 0 on the last beat, otherwise increments.
  - Latency: TX_TVALID is high the cycle after the second input handshake.
- Back-to-back: with TX_TREADY held high, the block sustains 1 RX beat/cycle and 1 TX beat every 2 cycles. There are no bubbles on RX.
- tx_valid clears on tx_hs unless a new beat is loaded in the same cycle. A new load takes priority.
- TX_TDATA/TLAST hold stable while TX_TVALID=1 and TX_TREADY=0 (AXIS rule).
- Flush:
  - FLUSH=1 sets flush_pending next cycle, which holds RX_TREADY low.
  - An RX handshake in the same cycle as FLUSH completes normally, and the flush acts on the resulting state.
  - Servicing happens in the first cycle with flush_pending && slot_free:
    - If lo_valid=1: tx_data <= {256'b0, lo_data}, tx_valid <= 1, tx_last <= 1, lo_valid <= 0, out_count <= 0.
    - If lo_valid=0: no output, and out_count is unchanged.
    - In both cases flush_pending <= 0.
  - FLUSH while flush_pending=1 is absorbed; it is not queued.
- FLUSH_BUSY = flush_pending.
- PACKET_BEATS=1: every output beat has TLAST=1.
- Reset mid-packet discards the held half, the output beat and the count. There is no partial TLAST.

Test Plan:
- Reset with RX_TVALID=1 -> TX_TVALID=0, RX_TREADY=1 on the first clock after release; TX_TDATA=0.
- PACKET_BEATS=4; 8 RX beats of values 1..8, TX_TREADY=1 -> 4 TX beats with {2,1},{4,3},{6,5},{8,7} in [511:256],[255:0]; TLAST only on the 4th; RX_TREADY never drops.
- Same stream with TX_TREADY low for 5 cycles after the first TX beat -> TX data/TLAST held stable; RX_TREADY drops once lo is full; no beat lost or duplicated; count resumes correctly.
- 3 RX beats (A,B,C) then FLUSH -> beats {B,A} TLAST=0, then {0,C} TLAST=1; FLUSH_BUSY high for exactly 1 cycle when the slot is free; next packet starts with out_count=0.
- FLUSH with lo empty -> no TX beat; TLAST position of the following packet unchanged. FLUSH in the same cycle as the RX handshake of C -> C is captured, then flushed as {0,C} TLAST=1.
- resetn asserted asynchronously between the 1st and 2nd RX beats -> all outputs clear immediately; the next two beats pair from scratch.
